// File: rtl/lc3b_cache.sv
// LC-3b two-way set-associative write-back cache.
// 8 sets x 2 ways of 128-bit lines.
package lc3b_cache_pkg;
  typedef logic [127:0] lc3b_line;
  typedef logic [8:0]   lc3b_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
endpackage

module lc3b_cache
  import lc3b_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_line      pmem_wdata,
  input  lc3b_line      pmem_rdata,
  input  logic          pmem_resp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0][1:0] valid_q, valid_d;
  logic [7:0][1:0] dirty_q, dirty_d;
  logic [7:0] lru_q, lru_d;
  lc3b_tag  [7:0][1:0] tag_q, tag_d;
  lc3b_line [7:0][1:0] data_q, data_d;

  lc3b_tag      tag;
  lc3b_c_index  idx;
  lc3b_c_offset off;
  logic         off_unused;
  logic         req, hit0, hit1, hit, hway, vway;
  lc3b_line     hline, wline;
  lc3b_word     hword, wword;

  assign tag = mem_address[15:7];
  assign idx = mem_address[6:4];
  assign off = mem_address[3:0];
  assign off_unused = off[0];

  // Lookup, victim choice and write merge.
  always_comb begin
    req   = mem_read | mem_write;
    hit0  = valid_q[idx][0] && (tag_q[idx][0] == tag);
    hit1  = valid_q[idx][1] && (tag_q[idx][1] == tag);
    hit   = hit0 | hit1;
    hway  = hit1;
    if (!valid_q[idx][0])      vway = 1'b0;
    else if (!valid_q[idx][1]) vway = 1'b1;
    else                       vway = lru_q[idx];
    hline = data_q[idx][hway];
    hword = hline[{off[3:1], 4'b0} +: 16];
    wword = hword;
    if (mem_byte_enable[0]) wword[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) wword[15:8] = mem_wdata[15:8];
    wline = hline;
    wline[{off[3:1], 4'b0} +: 16] = wword;
  end

  // Controller: outputs and next array/state values.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_rdata    = hword;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, idx, 4'b0};
    pmem_wdata   = data_q[idx][vway];
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req && hit) begin
          mem_resp = 1'b1;
          lru_d[idx] = ~hway;
          if (mem_write) begin
            data_d[idx][hway]  = wline;
            dirty_d[idx][hway] = 1'b1;
          end
        end else if (req) begin
          if (valid_q[idx][vway] && dirty_q[idx][vway])
            state_d = S_WB;
          else
            state_d = S_ALLOC;
        end
      end
      (state_q == S_WB): begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][vway], idx, 4'b0};
        if (pmem_resp) state_d = S_ALLOC;
      end
      (state_q == S_ALLOC): begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_d[idx][vway]  = pmem_rdata;
          tag_d[idx][vway]   = tag;
          valid_d[idx][vway] = 1'b1;
          dirty_d[idx][vway] = 1'b0;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and per-line status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
    end
  end

  // Tag and data arrays are never cleared.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
